bram_req_adapter: RTL

Request/response front-end that sits directly upstream of the single-port byte-enable BRAM in the vector-crypto subsystem FPGA build. It accepts valid/ready memory requests, drives the BRAM port controls, tracks the fixed BRAM read latency (1 or 2 cycles), and returns one in-order response per request through a response FIFO. Credit-based admission ensures BRAM output data is never lost under downstream backpressure.

---
 rtl/bram_req_adapter.sv | 105 ++++++++++
 1 files changed

// File: rtl/bram_req_adapter.sv
// Valid/ready front-end for a single-port byte-enable BRAM.
// Credits cover in-flight reads plus queued responses, so BRAM data is never dropped.
module bram_req_adapter #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int BYTE_WIDTH   = 8,
  parameter  int RAM_DEPTH    = 1024,
  parameter  int READ_LATENCY = 2,
  parameter  int RSP_DEPTH    = 4,
  localparam int NB_BYTES     = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH,
  localparam int ADDR_WIDTH   = $clog2(RAM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [NB_BYTES-1:0]   req_be_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  bram_re_o,
  output logic [NB_BYTES-1:0]   bram_we_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [DATA_WIDTH-1:0] bram_wdata_o,
  output logic                  bram_regce_o,
  input  logic [DATA_WIDTH-1:0] bram_rdata_i
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end
  if (RSP_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
    $error("RSP_DEPTH must be at least READ_LATENCY+1");
  end

  logic                    fire;
  logic                    push;
  logic                    pop;
  logic                    empty;
  logic [READ_LATENCY-1:0] vld;
  logic [CW-1:0]           outstanding;
  logic [CW-1:0]           count;
  logic [PW-1:0]           wptr;
  logic [PW-1:0]           rptr;
  logic [DATA_WIDTH-1:0]   mem [RSP_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Admission depends only on registered credit state and reset.
  assign req_ready_o  = !rst_i && (outstanding < DEPTH_C);
  assign fire         = req_valid_i & req_ready_o;

  assign bram_re_o    = fire;
  assign bram_we_o    = (fire && req_we_i) ? req_be_i : '0;
  assign bram_addr_o  = req_addr_i;
  assign bram_wdata_o = req_wdata_i;

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk_i) begin
      if (rst_i) vld <= '0;
      else       vld <= fire;
    end
    assign bram_regce_o = 1'b1;
  end else begin : g_lat2
    always_ff @(posedge clk_i) begin
      if (rst_i) vld <= '0;
      else       vld <= {vld[0], fire};
    end
    assign bram_regce_o = vld[0];
  end

  assign push        = vld[READ_LATENCY-1];
  assign empty       = (count == '0);
  assign pop         = !empty && rsp_ready_i;
  assign rsp_valid_o = !empty;
  assign rsp_rdata_o = empty ? '0 : mem[rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      outstanding <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(fire) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= bram_rdata_i;
  end

endmodule
